// File: rtl/bullet_pool_if.sv
// Bullet pool control/status bundle: fire requests, tank positions and the
// wall map flow into the pool; spawn/hit pulses and per-slot state flow out.
interface bullet_pool_if #(
    parameter int N_BULLETS = 8,
    parameter int MAP_DIM   = 16
);
    logic                              game_over;
    logic                              fire;
    logic [1:0]                        fire_dir;
    logic [9:0]                        shooter_x;
    logic [9:0]                        shooter_y;
    logic [9:0]                        oppo_x;
    logic [9:0]                        oppo_y;
    logic [MAP_DIM*MAP_DIM-1:0]        wall_map;
    logic                              fire_ack;
    logic                              fire_drop;
    logic                              hit;
    logic [7:0]                        hit_count;
    logic [N_BULLETS-1:0]              active_mask;
    logic [N_BULLETS-1:0][31:0]        bullet_state;

    modport master (
        output game_over, fire, fire_dir, shooter_x, shooter_y, oppo_x, oppo_y, wall_map,
        input  fire_ack, fire_drop, hit, hit_count, active_mask, bullet_state
    );

    modport slave (
        input  game_over, fire, fire_dir, shooter_x, shooter_y, oppo_x, oppo_y, wall_map,
        output fire_ack, fire_drop, hit, hit_count, active_mask, bullet_state
    );
endinterface

// File: rtl/bullet_pool.sv
// Fixed pool of bullet slots: spawns on fire (with cooldown), moves each live
// bullet on its own timer, retires bullets on walls/map edge and scores hits
// against the opponent tank.
module bullet_pool #(
    parameter int N_BULLETS   = 8,
    parameter int MOVE_TIME   = 80000000,
    parameter int STEP        = 1,
    parameter int COOLDOWN    = 800000,
    parameter int MAP_DIM     = 16,
    parameter int TILE_SHIFT  = 5,
    parameter int TANK_SIZE   = 32,
    parameter int BULLET_SIZE = 8
) (
    input  logic       clk,
    input  logic       reset,
    bullet_pool_if.slave bus
);
    localparam int MC_W = (MOVE_TIME > 0) ? $clog2(MOVE_TIME + 1) : 1;
    localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int TW   = (MAP_DIM > 1) ? $clog2(MAP_DIM) : 1;

    localparam logic [MC_W-1:0] MOVE_RELOAD = MC_W'(MOVE_TIME);
    localparam logic [CD_W-1:0] CD_RELOAD   = CD_W'(COOLDOWN);
    localparam logic [10:0]     STEP11      = 11'(STEP);
    localparam logic [10:0]     BS11        = 11'(BULLET_SIZE);
    localparam logic [10:0]     TS11        = 11'(TANK_SIZE);
    localparam logic [10:0]     MAP_PX11    = 11'(MAP_DIM << TILE_SHIFT);
    localparam logic [9:0]      C10         = 10'((TANK_SIZE - BULLET_SIZE) / 2);
    localparam logic [9:0]      BS10        = 10'(BULLET_SIZE);
    localparam logic [9:0]      TS10        = 10'(TANK_SIZE);

    logic [CD_W-1:0]      cooldown_reg;
    logic                 fire_ack_reg;
    logic                 fire_drop_reg;
    logic                 hit_reg;
    logic [7:0]           hit_count_reg;

    logic [N_BULLETS-1:0] active_vec;
    logic [N_BULLETS-1:0] overlap_vec;
    logic [N_BULLETS-1:0] spawn_sel;
    logic                 slot_free;
    logic                 eligible;
    logic                 do_spawn;
    logic                 any_hit;
    logic [9:0]           spawn_x;
    logic [9:0]           spawn_y;
    logic [2:0]           spawn_rom_col;

    assign eligible = bus.fire && !bus.game_over && (cooldown_reg == '0);
    assign do_spawn = eligible && slot_free;
    assign any_hit  = !bus.game_over && (|overlap_vec);

    // Pick the lowest-index slot that is idle right now (retiring slots stay busy).
    always_comb begin
        spawn_sel = '0;
        slot_free = 1'b0;
        for (int k = 0; k < N_BULLETS; k++) begin
            if (!active_vec[k] && !slot_free) begin
                spawn_sel[k] = 1'b1;
                slot_free    = 1'b1;
            end
        end
    end

    // Muzzle position and sprite column for the requested direction (10-bit wrap).
    always_comb begin
        spawn_x       = bus.shooter_x + TS10;
        spawn_y       = bus.shooter_y + C10;
        spawn_rom_col = 3'd2;
        case (bus.fire_dir)
            2'b00: begin
                spawn_x       = bus.shooter_x + C10;
                spawn_y       = bus.shooter_y - BS10;
                spawn_rom_col = 3'd1;
            end
            2'b01: begin
                spawn_x       = bus.shooter_x + C10;
                spawn_y       = bus.shooter_y + TS10;
                spawn_rom_col = 3'd0;
            end
            2'b10: begin
                spawn_x       = bus.shooter_x - BS10;
                spawn_y       = bus.shooter_y + C10;
                spawn_rom_col = 3'd3;
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BULLETS; gi++) begin : g_slot
            logic            active_reg;
            logic [9:0]      x_reg;
            logic [9:0]      y_reg;
            logic [1:0]      dir_reg;
            logic [2:0]      rom_col_reg;
            logic [MC_W-1:0] mcnt_reg;

            logic [10:0]     nx, ny, cx0, cy0, cx1, cy1;
            logic            under;
            logic            off_map;
            logic            wall_hit;
            logic            blocked;

            // Target position one step ahead plus the two leading-edge probe points.
            // Right/down probe the first pixel past the box, so the bullet stops
            // as soon as its front edge would touch a wall tile.
            always_comb begin
                nx    = {1'b0, x_reg};
                ny    = {1'b0, y_reg};
                under = 1'b0;
                case (dir_reg)
                    2'b00: begin
                        under = ({1'b0, y_reg} < STEP11);
                        ny    = {1'b0, y_reg} - STEP11;
                    end
                    2'b01:   ny = {1'b0, y_reg} + STEP11;
                    2'b10: begin
                        under = ({1'b0, x_reg} < STEP11);
                        nx    = {1'b0, x_reg} - STEP11;
                    end
                    default: nx = {1'b0, x_reg} + STEP11;
                endcase
                cx0 = nx;
                cx1 = nx + BS11 - 11'd1;
                cy0 = ny;
                cy1 = ny;
                case (dir_reg)
                    2'b00: ;
                    2'b01: begin
                        cy0 = ny + BS11;
                        cy1 = ny + BS11;
                    end
                    2'b10: begin
                        cx1 = nx;
                        cy1 = ny + BS11 - 11'd1;
                    end
                    default: begin
                        cx0 = nx + BS11;
                        cx1 = nx + BS11;
                        cy1 = ny + BS11 - 11'd1;
                    end
                endcase
            end

            assign off_map = under
                          || (nx + BS11 > MAP_PX11) || (ny + BS11 > MAP_PX11)
                          || (cx0 >= MAP_PX11) || (cx1 >= MAP_PX11)
                          || (cy0 >= MAP_PX11) || (cy1 >= MAP_PX11);
            assign wall_hit = bus.wall_map[{cy0[TILE_SHIFT +: TW], cx0[TILE_SHIFT +: TW]}]
                           || bus.wall_map[{cy1[TILE_SHIFT +: TW], cx1[TILE_SHIFT +: TW]}];
            assign blocked = off_map || wall_hit;

            assign overlap_vec[gi] = active_reg
                && ({1'b0, x_reg} + BS11 > {1'b0, bus.oppo_x})
                && ({1'b0, x_reg} < {1'b0, bus.oppo_x} + TS11)
                && ({1'b0, y_reg} + BS11 > {1'b0, bus.oppo_y})
                && ({1'b0, y_reg} < {1'b0, bus.oppo_y} + TS11);

            assign active_vec[gi]       = active_reg;
            assign bus.bullet_state[gi] = {1'b0, 2'b01, active_reg, x_reg, y_reg,
                                           dir_reg, 3'b000, rom_col_reg};

            // Slot lifecycle: clear on game over, spawn, retire on hit, else tick and move.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    active_reg  <= 1'b0;
                    x_reg       <= '0;
                    y_reg       <= '0;
                    dir_reg     <= '0;
                    rom_col_reg <= '0;
                    mcnt_reg    <= MOVE_RELOAD;
                end else if (bus.game_over) begin
                    active_reg <= 1'b0;
                end else if (do_spawn && spawn_sel[gi]) begin
                    active_reg  <= 1'b1;
                    x_reg       <= spawn_x;
                    y_reg       <= spawn_y;
                    dir_reg     <= bus.fire_dir;
                    rom_col_reg <= spawn_rom_col;
                    mcnt_reg    <= MOVE_RELOAD;
                end else if (active_reg) begin
                    if (overlap_vec[gi]) begin
                        active_reg <= 1'b0;
                    end else if (mcnt_reg != '0) begin
                        mcnt_reg <= mcnt_reg - 1'b1;
                    end else begin
                        mcnt_reg <= MOVE_RELOAD;
                        if (blocked) begin
                            active_reg <= 1'b0;
                        end else begin
                            x_reg <= nx[9:0];
                            y_reg <= ny[9:0];
                        end
                    end
                end
            end
        end
    endgenerate

    // Cooldown timer, fire/hit pulses and the saturating hit score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown_reg  <= '0;
            fire_ack_reg  <= 1'b0;
            fire_drop_reg <= 1'b0;
            hit_reg       <= 1'b0;
            hit_count_reg <= '0;
        end else begin
            if (do_spawn) begin
                cooldown_reg <= CD_RELOAD;
            end else if (cooldown_reg != '0) begin
                cooldown_reg <= cooldown_reg - 1'b1;
            end
            fire_ack_reg  <= do_spawn;
            fire_drop_reg <= eligible && !slot_free;
            hit_reg       <= any_hit;
            if (any_hit && hit_count_reg != 8'hFF) begin
                hit_count_reg <= hit_count_reg + 8'd1;
            end
        end
    end

    assign bus.fire_ack    = fire_ack_reg;
    assign bus.fire_drop   = fire_drop_reg;
    assign bus.hit         = hit_reg;
    assign bus.hit_count   = hit_count_reg;
    assign bus.active_mask = active_vec;
endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: 4 slots, move every 4 cycles, 1-px step,
// 5-cycle cooldown, 16x16 map with a wall border.
module tb_bullet_pool;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bullet_pool_if #(.N_BULLETS(4), .MAP_DIM(16)) bus ();

    bullet_pool #(
        .N_BULLETS(4), .MOVE_TIME(3), .STEP(1), .COOLDOWN(5),
        .MAP_DIM(16), .TILE_SHIFT(5), .TANK_SIZE(32), .BULLET_SIZE(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] st;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.fire      = 1'b0;
        bus.game_over = 1'b0;
        reset         = 1'b1;
        #3;
        reset         = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++; if (bus.active_mask !== 4'h0) begin errors++; $display("FAIL reset_mask got %b want 0000", bus.active_mask); end
        checks++; if (bus.fire_ack !== 1'b0 || bus.fire_drop !== 1'b0 || bus.hit !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b want 000", bus.fire_ack, bus.fire_drop, bus.hit); end
        checks++; if (bus.hit_count !== 8'd0) begin errors++; $display("FAIL reset_hit_count got %0d want 0", bus.hit_count); end
        checks++; if (bus.bullet_state[0] !== 32'h2000_0000) begin errors++; $display("FAIL reset_state got %h want 20000000", bus.bullet_state[0]); end
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_fire_up();
        do_reset();
        bus.shooter_x = 10'd100; bus.shooter_y = 10'd100; bus.fire_dir = 2'b00;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        checks++; if (bus.fire_ack !== 1'b1) begin errors++; $display("FAIL up_ack got %b want 1", bus.fire_ack); end
        st = {1'b0, 2'b01, 1'b1, 10'd112, 10'd92, 2'b00, 3'b000, 3'b001};
        checks++; if (bus.bullet_state[0] !== st) begin errors++; $display("FAIL up_spawn_state got %h want %h", bus.bullet_state[0], st); end
        $display("spawn up slot0 state %h", bus.bullet_state[0]);
        tick();
        checks++; if (bus.fire_ack !== 1'b0) begin errors++; $display("FAIL up_ack_pulse got %b want 0", bus.fire_ack); end
        tick(); tick();
        st = bus.bullet_state[0];
        checks++; if (st[17:8] !== 10'd92) begin errors++; $display("FAIL up_before_move got %0d want 92", st[17:8]); end
        tick();
        st = bus.bullet_state[0];
        checks++; if (st[17:8] !== 10'd91 || st[27:18] !== 10'd112) begin errors++; $display("FAIL up_after_move got (%0d,%0d) want (112,91)", st[27:18], st[17:8]); end
        $display("move up slot0 y=%0d", st[17:8]);
    endtask

    task automatic test_pool_full();
        logic exp_ack, exp_drop;
        do_reset();
        bus.shooter_x = 10'd100; bus.shooter_y = 10'd100; bus.fire_dir = 2'b00;
        bus.fire = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp_ack  = (c == 1) || (c == 7) || (c == 13) || (c == 19);
            exp_drop = (c >= 25);
            checks++;
            if (bus.fire_ack !== exp_ack || bus.fire_drop !== exp_drop) begin
                errors++;
                $display("FAIL pool_cycle%0d got ack=%b drop=%b want ack=%b drop=%b", c, bus.fire_ack, bus.fire_drop, exp_ack, exp_drop);
            end
            if (bus.fire_ack === 1'b1 || bus.fire_drop === 1'b1)
                $display("cycle %0d ack=%b drop=%b mask=%b", c, bus.fire_ack, bus.fire_drop, bus.active_mask);
            if (c == 1) begin
                checks++; if (bus.active_mask !== 4'b0001) begin errors++; $display("FAIL pool_mask_c1 got %b want 0001", bus.active_mask); end
            end
        end
        bus.fire = 1'b0;
        checks++; if (bus.active_mask !== 4'b1111) begin errors++; $display("FAIL pool_mask_full got %b want 1111", bus.active_mask); end
    endtask

    task automatic test_wall();
        do_reset();
        bus.shooter_x = 10'd439; bus.shooter_y = 10'd150; bus.fire_dir = 2'b11;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        st = {1'b0, 2'b01, 1'b1, 10'd471, 10'd162, 2'b11, 3'b000, 3'b010};
        checks++; if (bus.bullet_state[0] !== st) begin errors++; $display("FAIL wall_spawn got %h want %h", bus.bullet_state[0], st); end
        tick(); tick(); tick();
        checks++; if (bus.active_mask !== 4'b0001) begin errors++; $display("FAIL wall_pre_move got %b want 0001", bus.active_mask); end
        tick();
        st = bus.bullet_state[0];
        checks++; if (bus.active_mask !== 4'b0000 || st[27:18] !== 10'd471) begin errors++; $display("FAIL wall_blocked got mask=%b x=%0d want mask=0000 x=471", bus.active_mask, st[27:18]); end
        $display("wall move right x=%0d active=%b", st[27:18], st[28]);
    endtask

    task automatic test_hit();
        do_reset();
        bus.oppo_x = 10'd100; bus.oppo_y = 10'd60;
        bus.shooter_x = 10'd100; bus.shooter_y = 10'd100; bus.fire_dir = 2'b00;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        tick(); tick(); tick(); tick();
        st = bus.bullet_state[0];
        checks++; if (bus.hit !== 1'b0 || st[17:8] !== 10'd91 || bus.active_mask !== 4'b0001) begin errors++; $display("FAIL hit_pre got hit=%b y=%0d mask=%b want 0,91,0001", bus.hit, st[17:8], bus.active_mask); end
        tick();
        checks++; if (bus.hit !== 1'b1 || bus.active_mask !== 4'b0000 || bus.hit_count !== 8'd1) begin errors++; $display("FAIL hit_single got hit=%b mask=%b count=%0d want 1,0000,1", bus.hit, bus.active_mask, bus.hit_count); end
        $display("hit single count=%0d", bus.hit_count);
        tick();
        checks++; if (bus.hit !== 1'b0 || bus.hit_count !== 8'd1) begin errors++; $display("FAIL hit_pulse got hit=%b count=%0d want 0,1", bus.hit, bus.hit_count); end
        // two bullets, opponent moved onto both at once
        bus.oppo_x = 10'd600; bus.oppo_y = 10'd600;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        repeat (6) tick();
        bus.shooter_x = 10'd130; bus.shooter_y = 10'd80; bus.fire_dir = 2'b10;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        checks++; if (bus.fire_ack !== 1'b1 || bus.active_mask !== 4'b0011) begin errors++; $display("FAIL hit_two_spawn got ack=%b mask=%b want 1,0011", bus.fire_ack, bus.active_mask); end
        bus.oppo_x = 10'd100; bus.oppo_y = 10'd80;
        tick();
        checks++; if (bus.hit !== 1'b1 || bus.active_mask !== 4'b0000 || bus.hit_count !== 8'd2) begin errors++; $display("FAIL hit_double got hit=%b mask=%b count=%0d want 1,0000,2", bus.hit, bus.active_mask, bus.hit_count); end
        $display("hit double count=%0d", bus.hit_count);
        tick();
        checks++; if (bus.hit !== 1'b0 || bus.hit_count !== 8'd2) begin errors++; $display("FAIL hit_double_after got hit=%b count=%0d want 0,2", bus.hit, bus.hit_count); end
        bus.oppo_x = 10'd600; bus.oppo_y = 10'd600;
    endtask

    task automatic test_wrap();
        logic saw_hit;
        do_reset();
        saw_hit = 1'b0;
        bus.shooter_x = 10'd0; bus.shooter_y = 10'd0; bus.fire_dir = 2'b10;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        st = {1'b0, 2'b01, 1'b1, 10'd1016, 10'd12, 2'b10, 3'b000, 3'b011};
        checks++; if (bus.bullet_state[0] !== st) begin errors++; $display("FAIL wrap_spawn got %h want %h", bus.bullet_state[0], st); end
        for (int i = 0; i < 3; i++) begin tick(); saw_hit |= bus.hit; end
        checks++; if (bus.active_mask !== 4'b0001) begin errors++; $display("FAIL wrap_pre_move got %b want 0001", bus.active_mask); end
        tick(); saw_hit |= bus.hit;
        checks++; if (bus.active_mask !== 4'b0000 || saw_hit !== 1'b0 || bus.hit_count !== 8'd0) begin errors++; $display("FAIL wrap_retire got mask=%b hit=%b count=%0d want 0000,0,0", bus.active_mask, saw_hit, bus.hit_count); end
        $display("wrap left x=1016 retired mask=%b", bus.active_mask);
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.shooter_x = 10'd100; bus.shooter_y = 10'd200; bus.fire_dir = 2'b00;
        bus.fire = 1'b1;
        repeat (14) tick();
        bus.fire = 1'b0;
        checks++; if (bus.active_mask !== 4'b0111) begin errors++; $display("FAIL areset_pre got %b want 0111", bus.active_mask); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.active_mask !== 4'b0000) begin errors++; $display("FAIL areset_immediate got %b want 0000", bus.active_mask); end
        reset = 1'b0;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        checks++; if (bus.fire_ack !== 1'b1 || bus.active_mask !== 4'b0001) begin errors++; $display("FAIL areset_first_fire got ack=%b mask=%b want 1,0001", bus.fire_ack, bus.active_mask); end
        $display("async reset then fire mask=%b", bus.active_mask);
    endtask

    task automatic test_game_over();
        do_reset();
        bus.shooter_x = 10'd100; bus.shooter_y = 10'd200; bus.fire_dir = 2'b00;
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        repeat (5) tick();
        bus.fire = 1'b1;
        tick();
        checks++; if (bus.active_mask !== 4'b0011) begin errors++; $display("FAIL gover_pre got %b want 0011", bus.active_mask); end
        bus.game_over = 1'b1;
        tick();
        checks++; if (bus.active_mask !== 4'b0000 || bus.fire_ack !== 1'b0 || bus.fire_drop !== 1'b0) begin errors++; $display("FAIL gover_clear got mask=%b ack=%b drop=%b want 0000,0,0", bus.active_mask, bus.fire_ack, bus.fire_drop); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.fire_ack !== 1'b0 || bus.fire_drop !== 1'b0) begin errors++; $display("FAIL gover_ignore%0d got ack=%b drop=%b want 0,0", i, bus.fire_ack, bus.fire_drop); end
        end
        bus.game_over = 1'b0;
        tick();
        bus.fire = 1'b0;
        checks++; if (bus.fire_ack !== 1'b1 || bus.active_mask !== 4'b0001) begin errors++; $display("FAIL gover_release got ack=%b mask=%b want 1,0001", bus.fire_ack, bus.active_mask); end
        $display("game over release fire mask=%b", bus.active_mask);
    endtask

    initial begin
        logic [255:0] wm;
        wm = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                if (r == 0 || r == 15 || c == 0 || c == 15) wm[r*16 + c] = 1'b1;
        bus.wall_map  = wm;
        bus.game_over = 1'b0;
        bus.fire      = 1'b0;
        bus.fire_dir  = 2'b00;
        bus.shooter_x = 10'd0;
        bus.shooter_y = 10'd0;
        bus.oppo_x    = 10'd600;
        bus.oppo_y    = 10'd600;
        test_reset();
        test_fire_up();
        test_pool_full();
        test_wall();
        test_hit();
        test_wrap();
        test_async_reset();
        test_game_over();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
